// File: rtl/dpu_axis_dma_bridge.sv
// AXI-Stream <-> byte-wide PIO DMA bridge: one PIO command per byte, one read outstanding, DONE one cycle after the last byte.
// Backpressure: s_axis_tready only while waiting for a beat; cmd_valid and m_axis_tvalid hold their payload until accepted.
module dpu_axis_dma_bridge #(
    parameter int ADDR_BITS   = 24,
    parameter int AXIS_DATA_W = 64,
    parameter int MAX_WBUF    = 147456,
    parameter int MAX_CH      = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [AXIS_DATA_W-1:0]   s_axis_tdata,
    input  logic [AXIS_DATA_W/8-1:0] s_axis_tkeep,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    output logic [AXIS_DATA_W-1:0]   m_axis_tdata,
    output logic [AXIS_DATA_W/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    input  logic [2:0]               dma_target,
    input  logic [ADDR_BITS-1:0]     dma_base_addr,
    input  logic [ADDR_BITS-1:0]     dma_length,
    input  logic                     dma_dir,
    input  logic                     dma_start,
    input  logic                     dma_abort,
    output logic                     dma_busy,
    output logic                     dma_done,
    output logic                     dma_err,
    output logic [ADDR_BITS-1:0]     dma_count,
    output logic                     cmd_valid,
    input  logic                     cmd_ready,
    output logic [2:0]               cmd_type,
    output logic [ADDR_BITS-1:0]     cmd_addr,
    output logic [7:0]               cmd_data,
    input  logic                     rsp_valid,
    input  logic [7:0]               rsp_data
);
    localparam int NB = AXIS_DATA_W / 8;
    localparam int LW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [ADDR_BITS-1:0] BIAS_OFFSET = ADDR_BITS'(MAX_WBUF);
    localparam logic [ADDR_BITS-1:0] FMAP_OFFSET = ADDR_BITS'(MAX_WBUF + 4 * MAX_CH);

    typedef enum logic [2:0] {
        IDLE, WR_ACCEPT, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_PUSH, DONE
    } state_t;

    state_t state, state_nxt;
    logic [2:0]             tgt_q;
    logic                   dir_q;
    logic [ADDR_BITS-1:0]   len_q, cur_q, cnt_q;
    logic                   err_q, err_nxt, last_q;
    // Shared between modes: the write beat being drained, or the read beat being assembled
    logic [AXIS_DATA_W-1:0] buf_q;
    logic [NB-1:0]          lane_q;
    logic [LW-1:0]          rd_idx_q;

    logic [LW-1:0]          wr_lane;
    logic [NB-1:0]          lane_rest;
    logic [ADDR_BITS-1:0]   tgt_off, cnt_inc;
    logic                   cmd_hs, rsp_take, len_hit, rd_full, start_bad;

    always_comb begin
        wr_lane = '0;
        for (int i = NB - 1; i >= 0; i--)
            if (lane_q[i]) wr_lane = LW'(i);
    end

    always_comb begin
        case (tgt_q)
            3'd1:    tgt_off = FMAP_OFFSET;
            3'd2:    tgt_off = BIAS_OFFSET;
            default: tgt_off = '0;
        endcase
    end

    assign dma_busy      = (state != IDLE) && (state != DONE);
    assign dma_done      = (state == DONE);
    assign dma_err       = err_q;
    assign dma_count     = cnt_q;
    assign s_axis_tready = (state == WR_ACCEPT);
    assign cmd_valid     = ((state == WR_ISSUE) && (|lane_q)) || (state == RD_ISSUE);
    assign cmd_hs        = cmd_valid && cmd_ready;
    assign rsp_take      = rsp_valid && ((state == RD_WAIT) || ((state == RD_ISSUE) && cmd_ready));
    assign cnt_inc       = cnt_q + ADDR_BITS'(1);
    assign len_hit       = (cnt_inc == len_q);
    assign rd_full       = (rd_idx_q == LW'(NB - 1));
    assign lane_rest     = cmd_hs ? (lane_q & ~(NB'(1) << wr_lane)) : lane_q;
    assign start_bad     = (dma_target > 3'd4) || (dma_dir && (dma_target > 3'd2));

    assign cmd_addr = cmd_valid ? (cur_q + tgt_off) : '0;
    assign cmd_data = (state == WR_ISSUE) ? buf_q[8*wr_lane +: 8] : 8'h00;
    always_comb begin
        cmd_type = 3'd0;
        if (cmd_valid) begin
            if (dir_q)              cmd_type = 3'd2;
            else if (tgt_q == 3'd3) cmd_type = 3'd5;
            else if (tgt_q == 3'd4) cmd_type = 3'd6;
        end
    end

    assign m_axis_tvalid = (state == RD_PUSH);
    assign m_axis_tdata  = (state == RD_PUSH) ? buf_q : '0;
    assign m_axis_tkeep  = (state == RD_PUSH) ? lane_q : '0;
    assign m_axis_tlast  = (state == RD_PUSH) && (cnt_q == len_q);

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            IDLE: if (dma_start) begin
                err_nxt = start_bad;
                if (start_bad || (dma_length == '0)) state_nxt = DONE;
                else                                 state_nxt = dma_dir ? RD_ISSUE : WR_ACCEPT;
            end
            WR_ACCEPT: if (s_axis_tvalid) state_nxt = WR_ISSUE;
            WR_ISSUE: begin
                if (cmd_hs && len_hit) begin
                    state_nxt = DONE;
                end else if (lane_rest == '0) begin
                    state_nxt = last_q ? DONE : WR_ACCEPT;
                    err_nxt   = last_q;
                end
            end
            RD_ISSUE: begin
                if (rsp_take)    state_nxt = (rd_full || len_hit) ? RD_PUSH : RD_ISSUE;
                else if (cmd_hs) state_nxt = RD_WAIT;
            end
            RD_WAIT:  if (rsp_take) state_nxt = (rd_full || len_hit) ? RD_PUSH : RD_ISSUE;
            RD_PUSH:  if (m_axis_tready) state_nxt = (cnt_q == len_q) ? DONE : RD_ISSUE;
            DONE:     if (!dma_start) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (dma_abort && dma_busy) begin
            state_nxt = DONE;
            err_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            err_q    <= 1'b0;
            tgt_q    <= '0;
            dir_q    <= 1'b0;
            len_q    <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            buf_q    <= '0;
            lane_q   <= '0;
            rd_idx_q <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            case (state)
                IDLE: if (dma_start) begin
                    tgt_q    <= dma_target;
                    dir_q    <= dma_dir;
                    len_q    <= dma_length;
                    cur_q    <= dma_base_addr;
                    cnt_q    <= '0;
                    buf_q    <= '0;
                    lane_q   <= '0;
                    rd_idx_q <= '0;
                end
                WR_ACCEPT: if (s_axis_tvalid) begin
                    buf_q  <= s_axis_tdata;
                    lane_q <= s_axis_tkeep;
                    last_q <= s_axis_tlast;
                end
                WR_ISSUE: if (cmd_hs) begin
                    cur_q  <= cur_q + ADDR_BITS'(1);
                    cnt_q  <= cnt_inc;
                    lane_q <= lane_rest;
                end
                RD_ISSUE, RD_WAIT: begin
                    if (cmd_hs) cur_q <= cur_q + ADDR_BITS'(1);
                    if (rsp_take) begin
                        buf_q[8*rd_idx_q +: 8] <= rsp_data;
                        lane_q[rd_idx_q]       <= 1'b1;
                        rd_idx_q               <= rd_idx_q + LW'(1);
                        cnt_q                  <= cnt_inc;
                    end
                end
                RD_PUSH: if (m_axis_tready) begin
                    buf_q    <= '0;
                    lane_q   <= '0;
                    rd_idx_q <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dpu_axis_dma_bridge.sv
// Directed bench for dpu_axis_dma_bridge (NB=8): PIO/stream responder in a negedge process, scenarios as tasks.
module tb_dpu_axis_dma_bridge;
    localparam logic [23:0] FMAP = 24'h024400;
    localparam logic [23:0] BIAS = 24'h024000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic [63:0] s_axis_tdata = '0;
    logic [7:0]  s_axis_tkeep = '0;
    logic        s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
    logic [2:0]  dma_target = '0;
    logic [23:0] dma_base_addr = '0, dma_length = '0, dma_count;
    logic        dma_dir = 1'b0, dma_start = 1'b0, dma_abort = 1'b0;
    logic        dma_busy, dma_done, dma_err;
    logic        cmd_valid, cmd_ready = 1'b0;
    logic [2:0]  cmd_type;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic        rsp_valid = 1'b0;
    logic [7:0]  rsp_data = '0;

    int checks = 0, errors = 0;

    logic [2:0]  log_type[$];
    logic [23:0] log_addr[$];
    logic [7:0]  log_data[$];
    logic [63:0] beat_data[$];
    logic [7:0]  beat_keep[$];
    logic        beat_last[$];

    bit cmd_en, cmd_rnd, m_en, m_rnd, m_chk, m_prev_stall;
    int rsp_lat = 1, rsp_cnt = 0;
    logic [23:0] rsp_addr;
    logic [63:0] m_prev_data;
    logic [7:0]  m_prev_keep;

    dpu_axis_dma_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .dma_target(dma_target), .dma_base_addr(dma_base_addr), .dma_length(dma_length),
        .dma_dir(dma_dir), .dma_start(dma_start), .dma_abort(dma_abort),
        .dma_busy(dma_busy), .dma_done(dma_done), .dma_err(dma_err), .dma_count(dma_count),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_addr(cmd_addr),
        .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
    );

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Drives the ready/response inputs for the coming edge, then logs the handshakes that edge will complete.
    always @(negedge clk) begin
        if (m_chk && m_prev_stall) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== m_prev_data || m_axis_tkeep !== m_prev_keep) begin
                errors++;
                $display("FAIL m_axis_stable: valid=%b data=%h keep=%h, required valid=1 data=%h keep=%h",
                         m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_prev_data, m_prev_keep);
            end
        end
        rsp_valid     = 1'b0;
        cmd_ready     = cmd_en && (!cmd_rnd || ($urandom_range(0, 1) == 1));
        m_axis_tready = m_en && (!m_rnd || ($urandom_range(0, 1) == 1));
        m_prev_stall  = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        m_prev_data   = m_axis_tdata;
        m_prev_keep   = m_axis_tkeep;
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            beat_data.push_back(m_axis_tdata);
            beat_keep.push_back(m_axis_tkeep);
            beat_last.push_back(m_axis_tlast);
        end
        if (cmd_valid === 1'b1 && cmd_ready) begin
            log_type.push_back(cmd_type);
            log_addr.push_back(cmd_addr);
            log_data.push_back(cmd_data);
            if (cmd_type == 3'd2) begin
                if (rsp_lat == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_byte(cmd_addr);
                end else begin
                    rsp_cnt  = rsp_lat;
                    rsp_addr = cmd_addr;
                end
            end
        end else if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_byte(rsp_addr);
            end
        end
    end

    task automatic clear_logs();
        log_type.delete(); log_addr.delete(); log_data.delete();
        beat_data.delete(); beat_keep.delete(); beat_last.delete();
    endtask

    task automatic start_dma(input logic [2:0] t, input logic [23:0] b, input logic [23:0] l, input logic d);
        dma_target = t; dma_base_addr = b; dma_length = l; dma_dir = d; dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int n = 0;
        s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l; s_axis_tvalid = 1'b1;
        while (s_axis_tready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL s_axis_accept: tready=%b after %0d cycles, required 1", s_axis_tready, n);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (dma_done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dma_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: dma_done=%b after %0d cycles, required 1", name, dma_done, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_valid, s_axis_tready, m_axis_tvalid, m_axis_tlast, dma_err, dma_done, dma_busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {cmd_valid, s_axis_tready, m_axis_tvalid, m_axis_tlast, dma_err, dma_done, dma_busy});
        end
        checks++;
        if ({m_axis_tdata, m_axis_tkeep, cmd_type, cmd_addr, cmd_data, dma_count} !== '0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h tkeep=%h type=%0d addr=%h data=%h count=%0d, required all 0",
                     m_axis_tdata, m_axis_tkeep, cmd_type, cmd_addr, cmd_data, dma_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_fmap();
        cmd_en = 1; cmd_rnd = 1;
        clear_logs();
        start_dma(3'd1, 24'h10, 24'd10, 1'b0);
        send_beat(64'h0706050403020100, 8'hFF, 1'b0);
        send_beat(64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1);
        wait_done("fmap");
        checks++;
        if (dma_err !== 1'b0 || dma_count !== 24'd10) begin
            errors++;
            $display("FAIL fmap_status: err=%b count=%0d, required err=0 count=10", dma_err, dma_count);
        end
        checks++;
        if (log_addr.size() != 10) begin
            errors++;
            $display("FAIL fmap_ncmd: %0d writes, required 10", log_addr.size());
        end
        for (int i = 0; i < 10 && i < log_addr.size(); i++) begin
            checks++;
            if (log_type[i] !== 3'd0 || log_addr[i] !== FMAP + 24'h10 + 24'(i) || log_data[i] !== 8'(i)) begin
                errors++;
                $display("FAIL fmap_cmd%0d: type=%0d addr=%h data=%h, required type=0 addr=%h data=%h",
                         i, log_type[i], log_addr[i], log_data[i], FMAP + 24'h10 + 24'(i), 8'(i));
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (dma_done !== 1'b0 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL fmap_idle: done=%b busy=%b, required 0 0", dma_done, dma_busy);
        end
    endtask

    task automatic test_keep_gaps();
        logic [7:0] exp_d[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
        cmd_en = 1; cmd_rnd = 1;
        clear_logs();
        start_dma(3'd3, 24'h100, 24'd8, 1'b0);
        send_beat(64'h8877665544332211, 8'h0F, 1'b0);
        send_beat(64'hF0E0D0C0B0A09080, 8'hF0, 1'b0);
        wait_done("gaps");
        checks++;
        if (dma_err !== 1'b0 || dma_count !== 24'd8 || log_addr.size() != 8) begin
            errors++;
            $display("FAIL gaps_status: err=%b count=%0d ncmd=%0d, required err=0 count=8 ncmd=8",
                     dma_err, dma_count, log_addr.size());
        end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            checks++;
            if (log_type[i] !== 3'd5 || log_addr[i] !== 24'h100 + 24'(i) || log_data[i] !== exp_d[i]) begin
                errors++;
                $display("FAIL gaps_cmd%0d: type=%0d addr=%h data=%h, required type=5 addr=%h data=%h",
                         i, log_type[i], log_addr[i], log_data[i], 24'h100 + 24'(i), exp_d[i]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_targets();
        logic [2:0]  tt[3] = '{3'd4, 3'd2, 3'd1};
        logic [23:0] tb_base[3] = '{24'h1234, 24'h20, 24'hFFFFFF};
        logic [2:0]  ex_type[3] = '{3'd6, 3'd0, 3'd0};
        logic [23:0] ex_addr[3] = '{24'h001234, 24'h024020, 24'h0243FF};
        cmd_en = 1; cmd_rnd = 0;
        for (int i = 0; i < 3; i++) begin
            clear_logs();
            start_dma(tt[i], tb_base[i], 24'd1, 1'b0);
            send_beat(64'h5A, 8'h01, 1'b1);
            wait_done("target");
            checks++;
            if (log_addr.size() != 1 || log_type[0] !== ex_type[i] || log_addr[0] !== ex_addr[i] ||
                log_data[0] !== 8'h5A || dma_err !== 1'b0) begin
                errors++;
                $display("FAIL target%0d_cmd: n=%0d type=%0d addr=%h err=%b, required n=1 type=%0d addr=%h err=0",
                         tt[i], log_addr.size(), log_type.size() > 0 ? log_type[0] : 3'd7,
                         log_addr.size() > 0 ? log_addr[0] : 24'hX, dma_err, ex_type[i], ex_addr[i]);
            end
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            clear_logs();
            start_dma(i == 0 ? 3'd5 : 3'd3, 24'h0, 24'd4, i == 0 ? 1'b0 : 1'b1);
            checks++;
            if (dma_done !== 1'b1 || dma_err !== 1'b1 || dma_busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_target%0d: done=%b err=%b busy=%b, required 1 1 0", i, dma_done, dma_err, dma_busy);
            end
            repeat (3) @(negedge clk);
            checks++;
            if (log_addr.size() != 0) begin
                errors++;
                $display("FAIL bad_target%0d_cmds: %0d commands, required 0", i, log_addr.size());
            end
        end
    endtask

    task automatic test_read();
        cmd_en = 1; cmd_rnd = 1; m_en = 1; m_rnd = 1; rsp_lat = 1; m_chk = 1;
        clear_logs();
        start_dma(3'd0, 24'h40, 24'd11, 1'b1);
        wait_done("read");
        m_chk = 0;
        checks++;
        if (dma_err !== 1'b0 || dma_count !== 24'd11 || beat_data.size() != 2 || log_addr.size() != 11) begin
            errors++;
            $display("FAIL read_status: err=%b count=%0d beats=%0d reads=%0d, required 0 11 2 11",
                     dma_err, dma_count, beat_data.size(), log_addr.size());
        end
        for (int i = 0; i < 11 && i < log_addr.size(); i++) begin
            checks++;
            if (log_type[i] !== 3'd2 || log_addr[i] !== 24'h40 + 24'(i)) begin
                errors++;
                $display("FAIL read_cmd%0d: type=%0d addr=%h, required type=2 addr=%h",
                         i, log_type[i], log_addr[i], 24'h40 + 24'(i));
            end
        end
        if (beat_data.size() == 2) begin
            checks++;
            if (beat_data[0] !== 64'hE2E3E0E1E6E7E4E5 || beat_keep[0] !== 8'hFF || beat_last[0] !== 1'b0) begin
                errors++;
                $display("FAIL read_beat0: data=%h keep=%h last=%b, required E2E3E0E1E6E7E4E5 ff 0",
                         beat_data[0], beat_keep[0], beat_last[0]);
            end
            checks++;
            if (beat_data[1] !== 64'h0000000000EFECED || beat_keep[1] !== 8'h07 || beat_last[1] !== 1'b1) begin
                errors++;
                $display("FAIL read_beat1: data=%h keep=%h last=%b, required 0000000000EFECED 07 1",
                         beat_data[1], beat_keep[1], beat_last[1]);
            end
        end
        repeat (2) @(negedge clk);
        // Response in the same cycle as cmd_ready, bias target
        cmd_rnd = 0; m_rnd = 0; rsp_lat = 0;
        clear_logs();
        start_dma(3'd2, 24'h8, 24'd3, 1'b1);
        wait_done("read_bias");
        checks++;
        if (log_addr.size() != 3 || log_addr[0] !== 24'h024008 || log_addr[2] !== 24'h02400A || dma_count !== 24'd3) begin
            errors++;
            $display("FAIL read_bias_cmds: n=%0d count=%0d, required n=3 addr 024008..02400a count=3",
                     log_addr.size(), dma_count);
        end
        checks++;
        if (beat_data.size() != 1 || beat_data[0] !== 64'h0000000000AFACAD || beat_keep[0] !== 8'h07 ||
            beat_last[0] !== 1'b1) begin
            errors++;
            $display("FAIL read_bias_beat: n=%0d data=%h, required n=1 data=0000000000AFACAD keep=07 last=1",
                     beat_data.size(), beat_data.size() > 0 ? beat_data[0] : 64'hX);
        end
        rsp_lat = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_short_stream();
        cmd_en = 1; cmd_rnd = 0;
        clear_logs();
        start_dma(3'd0, 24'h0, 24'd16, 1'b0);
        send_beat(64'h0123456789ABCDEF, 8'hFF, 1'b1);
        wait_done("short");
        checks++;
        if (dma_err !== 1'b1 || dma_count !== 24'd8 || log_addr.size() != 8) begin
            errors++;
            $display("FAIL short_status: err=%b count=%0d ncmd=%0d, required err=1 count=8 ncmd=8",
                     dma_err, dma_count, log_addr.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall_abort();
        int n = 0;
        cmd_en = 0;
        clear_logs();
        @(negedge clk);
        start_dma(3'd0, 24'h200, 24'd4, 1'b0);
        send_beat(64'h000000000000CDAB, 8'h03, 1'b0);
        while (cmd_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (cmd_valid !== 1'b1 || cmd_addr !== 24'h200 || cmd_data !== 8'hAB || cmd_type !== 3'd0 ||
                dma_busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b addr=%h data=%h type=%0d busy=%b, required 1 000200 ab 0 1",
                         c, cmd_valid, cmd_addr, cmd_data, cmd_type, dma_busy);
            end
            dma_start = (c == 5);
            if (c == 5) begin
                dma_target = 3'd1; dma_base_addr = 24'h777;
            end
            @(negedge clk);
        end
        dma_start = 1'b0;
        dma_abort = 1'b1;
        @(negedge clk);
        dma_abort = 1'b0;
        checks++;
        if (dma_done !== 1'b1 || dma_err !== 1'b1 || cmd_valid !== 1'b0 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL abort: done=%b err=%b cmd_valid=%b busy=%b, required 1 1 0 0",
                     dma_done, dma_err, cmd_valid, dma_busy);
        end
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL abort_cmds: %0d writes, required 0", log_addr.size());
        end
        cmd_en = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_len_zero();
        cmd_en = 1;
        clear_logs();
        start_dma(3'd0, 24'h300, 24'd0, 1'b0);
        checks++;
        if (dma_done !== 1'b1 || dma_err !== 1'b0 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL len0: done=%b err=%b busy=%b, required 1 0 0", dma_done, dma_err, dma_busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (log_addr.size() != 0) begin
            errors++;
            $display("FAIL len0_cmds: %0d commands, required 0", log_addr.size());
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        cmd_en = 1; cmd_rnd = 0; m_en = 0; rsp_lat = 1;
        clear_logs();
        start_dma(3'd0, 24'h0, 24'd20, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tkeep !== 8'hFF) begin
            errors++;
            $display("FAIL rdrst_push: tvalid=%b tkeep=%h, required 1 ff", m_axis_tvalid, m_axis_tkeep);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rsp_cnt = 0;
        checks++;
        if ({cmd_valid, s_axis_tready, m_axis_tvalid, m_axis_tlast, dma_err, dma_done, dma_busy} !== 7'b0 ||
            {m_axis_tdata, m_axis_tkeep, cmd_type, cmd_addr, cmd_data, dma_count} !== '0) begin
            errors++;
            $display("FAIL rdrst_outputs: valid=%b tvalid=%b busy=%b tdata=%h count=%0d, required all 0",
                     cmd_valid, m_axis_tvalid, dma_busy, m_axis_tdata, dma_count);
        end
        n = log_addr.size();
        rst_n = 1'b1;
        m_en = 1;
        repeat (10) @(negedge clk);
        checks++;
        if (log_addr.size() != n || dma_busy !== 1'b0 || beat_data.size() != 0) begin
            errors++;
            $display("FAIL rdrst_quiet: cmds %0d->%0d busy=%b beats=%0d, required no change, 0, 0",
                     n, log_addr.size(), dma_busy, beat_data.size());
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_fmap();
        test_keep_gaps();
        test_targets();
        test_read();
        test_short_stream();
        test_stall_abort();
        test_len_zero();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
